dropout_mask_gen: RTL and testbench
===================================

DROPOUT_MASK_GEN -- requirements
Module: dropout_mask_gen

Interface
REQ-001 Parameter: MASK_WIDTH, default 8, number of mask bits per output word.
REQ-002 Parameter: DEFAULT_SEED, default 16'hACE1, LFSR value after reset and substitute for a zero seed.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: ena  input  1  generation enable; low pauses bit generation.
REQ-006 Port: keep_thr  input  8  keep threshold; keep probability = keep_thr/256.
REQ-007 Port: seed_load  input  1  single-cycle request to load seed_in into the LFSR.
REQ-008 Port: seed_in  input  16  seed value.
REQ-009 Port: mask  output  MASK_WIDTH  generated keep mask (1 = keep, 0 = drop); feeds the dropout stage.
REQ-010 Port: mask_valid  output  1  mask holds a complete, unconsumed word.
REQ-011 Port: mask_ready  input  1  consumer accepts mask when high with mask_valid.
REQ-012 Port: keep_count  output  4  popcount of mask, valid with mask_valid.
REQ-013 Port: mask_cnt  output  8  number of accepted masks, modulo 256.
REQ-014 Port: busy  output  1  high while in GEN.

Function
REQ-015 LFSR: 16-bit Galois, right shift, taps 16'hB400; next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
REQ-016 FSM states IDLE, GEN, VALID; no other reachable state.
REQ-017 IDLE: on an edge with ena=1 -> GEN, bit index cleared to 0, keep_thr captured into an internal register; ena=0 -> stay IDLE.
REQ-018 GEN, ena=1 edge: mask bit[index] <= (lfsr[7:0] < captured thr), LFSR advances once, index increments.
REQ-019 GEN, ena=0 edge: LFSR, index, partial mask all hold (pause), state stays GEN.
REQ-020 GEN: edge producing bit MASK_WIDTH-1 -> VALID; mask_valid and keep_count update on the same edge.
REQ-021 Latency: with ena held high, mask_valid rises MASK_WIDTH+1 edges after the IDLE->GEN edge's preceding sample; i.e. 9 edges after leaving reset for MASK_WIDTH=8.
REQ-022 VALID: mask, keep_count, mask_valid held stable regardless of ena or keep_thr until handshake; LFSR frozen.
REQ-023 Handshake = mask_valid & mask_ready at an edge; mask_cnt increments (wraps 255->0); next state GEN (thr re-captured, index 0) if ena=1, else IDLE.
REQ-024 Back-to-back throughput: one mask per MASK_WIDTH+1 cycles with ena and mask_ready held high.
REQ-025 mask_valid drops on the handshake edge; mask register keeps last value until overwritten by next completion.
REQ-026 keep_thr=0: every bit dropped (mask all zeros); keep_thr changes mid-GEN have no effect on the current word.
REQ-027 seed_load=1 at an edge in any state: LFSR <= seed_in, or DEFAULT_SEED if seed_in==0; state -> IDLE; mask_valid -> 0; partial mask discarded.
REQ-028 seed_load simultaneous with handshake: seed_load wins; mask_cnt does not increment.
REQ-029 LFSR never holds zero.

Reset
REQ-030 rst_n low: immediately LFSR=DEFAULT_SEED, state IDLE, mask=0, mask_valid=0, keep_count=0, mask_cnt=0, busy=0, index=0, captured thr=0.
REQ-031 Reset mid-GEN or mid-VALID: word discarded, no handshake counted; operation resumes from IDLE on first edge after rst_n high.

Verification
REQ-032 Reset then ena=1, keep_thr=0, mask_ready=1 -> mask_valid after 9 edges, mask=8'h00, keep_count=0, mask_cnt increments each 9 cycles.
REQ-033 keep_thr=8'h80, 1000 masks vs reference LFSR model -> bit-exact match; kept-bit fraction within 0.45-0.55.
REQ-034 mask_ready=0 for 20 cycles in VALID -> mask/keep_count/mask_valid stable, LFSR unchanged, mask_cnt unchanged.
REQ-035 ena=0 for 5 cycles mid-GEN -> completion delayed exactly 5 cycles, mask identical to unpaused run.
REQ-036 seed_load with seed_in=0 -> mask sequence identical to post-reset sequence; seed_load with handshake same edge -> mask_valid=0, mask_cnt unchanged.
REQ-037 rst_n pulsed low asynchronously mid-GEN -> all outputs at REQ-030 values before next clock edge.

Source files
------------

// File: rtl/dropout_mask_gen.sv
// Dropout keep-mask generator: a 16-bit Galois LFSR is compared against a
// captured threshold one bit per enabled cycle, producing MASK_WIDTH-bit words behind a valid/ready handshake.
module dropout_mask_gen #(
   parameter int          MASK_WIDTH   = 8,
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [7:0]            keep_thr,
   input  logic                  seed_load,
   input  logic [15:0]           seed_in,
   output logic [MASK_WIDTH-1:0] mask,
   output logic                  mask_valid,
   input  logic                  mask_ready,
   output logic [3:0]            keep_count,
   output logic [7:0]            mask_cnt,
   output logic                  busy
);

   localparam int              IDX_W    = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;
   localparam logic [15:0]     TAPS     = 16'hB400;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASK_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_VALID} state_t;

   state_t                r_state, w_state_next;
   logic [15:0]           r_lfsr;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_thr;
   logic [MASK_WIDTH-1:0] r_partial;
   logic [MASK_WIDTH-1:0] r_mask;
   logic [3:0]            r_keep_count;
   logic [7:0]            r_mask_cnt;

   logic                  w_handshake;
   logic                  w_gen_step;
   logic                  w_last_bit;
   logic                  w_start;
   logic [15:0]           w_lfsr_next;
   logic [15:0]           w_seed;
   logic [MASK_WIDTH-1:0] w_partial_next;
   logic [3:0]            w_popcount;

   assign w_handshake = (r_state == S_VALID) && mask_ready;
   assign w_gen_step  = (r_state == S_GEN) && ena;
   assign w_last_bit  = w_gen_step && (r_idx == LAST_IDX);
   // A new word starts (threshold captured) from IDLE or straight out of a handshake.
   assign w_start     = ((r_state == S_IDLE) && ena) || (w_handshake && ena);
   assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);
   assign w_seed      = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_partial_next        = r_partial;
      w_partial_next[r_idx] = (r_lfsr[7:0] < r_thr);
   end

   always_comb begin
      w_popcount = '0;
      for (int i = 0; i < MASK_WIDTH; i++) begin
         w_popcount = w_popcount + 4'(w_partial_next[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (ena)        w_state_next = S_GEN;
         S_GEN:   if (w_last_bit) w_state_next = S_VALID;
         S_VALID: if (mask_ready) w_state_next = ena ? S_GEN : S_IDLE;
         default:                 w_state_next = S_IDLE;
      endcase
      if (seed_load) begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr       <= DEFAULT_SEED;
         r_idx        <= '0;
         r_thr        <= '0;
         r_partial    <= '0;
         r_mask       <= '0;
         r_keep_count <= '0;
         r_mask_cnt   <= '0;
      end else if (seed_load) begin
         // Reseeding abandons any word in flight, including one being handed off this edge.
         r_lfsr    <= w_seed;
         r_idx     <= '0;
         r_partial <= '0;
      end else begin
         if (w_start) begin
            r_idx     <= '0;
            r_thr     <= keep_thr;
            r_partial <= '0;
         end
         if (w_gen_step) begin
            r_lfsr    <= w_lfsr_next;
            r_partial <= w_partial_next;
            r_idx     <= r_idx + 1'b1;
            if (w_last_bit) begin
               r_mask       <= w_partial_next;
               r_keep_count <= w_popcount;
               r_idx        <= '0;
            end
         end
         if (w_handshake) begin
            r_mask_cnt <= r_mask_cnt + 8'd1;
         end
      end
   end

   assign mask       = r_mask;
   assign mask_valid = (r_state == S_VALID);
   assign keep_count = r_keep_count;
   assign mask_cnt   = r_mask_cnt;
   assign busy       = (r_state == S_GEN);

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Self-checking bench for dropout_mask_gen: word-level reference model of the
// LFSR/threshold rule, directed corner cases plus a randomized ena/stall/threshold phase.
module tb_dropout_mask_gen;

   localparam int          MW    = 8;
   localparam logic [15:0] DSEED = 16'hACE1;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b1;
   logic          ena        = 1'b0;
   logic [7:0]    keep_thr   = 8'h00;
   logic          seed_load  = 1'b0;
   logic [15:0]   seed_in    = 16'h0000;
   logic          mask_ready = 1'b0;
   logic [MW-1:0] mask;
   logic          mask_valid;
   logic [3:0]    keep_count;
   logic [7:0]    mask_cnt;
   logic          busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] m_lfsr;
   int          m_cnt;
   int          kept_total;

   dropout_mask_gen #(.MASK_WIDTH(MW), .DEFAULT_SEED(DSEED)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .keep_thr   (keep_thr),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .mask       (mask),
      .mask_valid (mask_valid),
      .mask_ready (mask_ready),
      .keep_count (keep_count),
      .mask_cnt   (mask_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Next word: one keep decision per LFSR state, keep when low byte < threshold.
   function automatic logic [MW-1:0] model_word(input logic [7:0] thr);
      logic [MW-1:0] w;
      w = '0;
      for (int i = 0; i < MW; i++) begin
         w[i]   = (m_lfsr[7:0] < thr);
         m_lfsr = lfsr_step(m_lfsr);
      end
      return w;
   endfunction

   task automatic do_reset(input logic [7:0] thr);
      rst_n      = 1'b0;
      ena        = 1'b0;
      seed_load  = 1'b0;
      seed_in    = 16'h0000;
      mask_ready = 1'b0;
      keep_thr   = thr;
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = DSEED;
      m_cnt  = 0;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!mask_valid && edges < 200) begin
         @(negedge clk);
         edges++;
      end
      if (!mask_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic take_word(input string tag, input logic [7:0] thr, input int exp_edges);
      int            e;
      logic [MW-1:0] w;
      wait_valid(e);
      check({tag, "_lat"}, e, exp_edges);
      w = model_word(thr);
      check({tag, "_mask"}, mask, w);
      check({tag, "_kc"}, keep_count, $countones(w));
      kept_total += $countones(mask);
      if (mask_ready) begin
         @(negedge clk);
         m_cnt++;
         check({tag, "_cnt"}, mask_cnt, m_cnt % 256);
         check({tag, "_drop"}, mask_valid, 1'b0);
         check({tag, "_hold"}, mask, w);
      end
   endtask

   initial begin
      int            e;
      logic [MW-1:0] w;
      logic [15:0]   s;
      logic [7:0]    cap;
      int            guard;
      int            stall;

      // Asynchronous reset values, before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_mask", mask, 0);
      check("rst_valid", mask_valid, 0);
      check("rst_kc", keep_count, 0);
      check("rst_cnt", mask_cnt, 0);
      check("rst_busy", busy, 0);

      // Threshold zero: all-drop words, first after 9 edges then every 9.
      do_reset(8'h00);
      ena        = 1'b1;
      mask_ready = 1'b1;
      take_word("thr0_first", 8'h00, 9);
      for (int i = 0; i < 3; i++) take_word("thr0_next", 8'h00, 8);

      // Thousand words at half threshold, bit-exact and statistically balanced.
      do_reset(8'h80);
      ena        = 1'b1;
      mask_ready = 1'b1;
      kept_total = 0;
      take_word("half_first", 8'h80, 9);
      for (int i = 1; i < 1000; i++) take_word("half", 8'h80, 8);
      check("half_fraction", (kept_total >= 3600 && kept_total <= 4400), 1);

      // Consumer stall of 20 cycles: everything frozen, including the LFSR.
      do_reset(8'h5A);
      ena        = 1'b1;
      mask_ready = 1'b0;
      wait_valid(e);
      check("stall_lat", e, 9);
      w = model_word(8'h5A);
      for (int i = 0; i < 20; i++) begin
         ena      = 1'($urandom);
         keep_thr = 8'($urandom);
         @(negedge clk);
         check("stall_mask", mask, w);
         check("stall_valid", mask_valid, 1);
         check("stall_kc", keep_count, $countones(w));
         check("stall_cnt", mask_cnt, 0);
      end
      ena        = 1'b1;
      keep_thr   = 8'h5A;
      mask_ready = 1'b1;
      @(negedge clk);
      m_cnt++;
      check("stall_release_cnt", mask_cnt, m_cnt);
      take_word("stall_next", 8'h5A, 8);

      // Five-cycle ena pause mid-word, with a threshold change that must be ignored.
      do_reset(8'h80);
      ena        = 1'b1;
      mask_ready = 1'b1;
      repeat (4) @(negedge clk);
      ena      = 1'b0;
      keep_thr = 8'hFF;
      repeat (5) @(negedge clk);
      check("pause_busy", busy, 1);
      check("pause_valid", mask_valid, 0);
      ena      = 1'b1;
      keep_thr = 8'h80;
      take_word("pause", 8'h80, 5);

      // Zero seed behaves like reset; nonzero seed restarts from that value.
      do_reset(8'h33);
      ena        = 1'b1;
      mask_ready = 1'b1;
      take_word("seed_pre", 8'h33, 9);
      repeat (3) @(negedge clk);
      seed_load = 1'b1;
      seed_in   = 16'h0000;
      @(negedge clk);
      seed_load = 1'b0;
      check("seed0_valid", mask_valid, 0);
      check("seed0_busy", busy, 0);
      m_lfsr = DSEED;
      take_word("seed0_a", 8'h33, 9);
      take_word("seed0_b", 8'h33, 8);
      repeat (2) @(negedge clk);
      s         = 16'($urandom_range(1, 65535));
      seed_load = 1'b1;
      seed_in   = s;
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr    = s;
      take_word("seedn_a", 8'h33, 9);
      take_word("seedn_b", 8'h33, 8);

      // Seed load on the handshake edge wins: no count, valid drops.
      mask_ready = 1'b0;
      wait_valid(e);
      w = model_word(8'h33);
      check("seedhs_mask", mask, w);
      s          = 16'($urandom_range(1, 65535));
      seed_load  = 1'b1;
      seed_in    = s;
      mask_ready = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      check("seedhs_valid", mask_valid, 0);
      check("seedhs_cnt", mask_cnt, m_cnt % 256);
      check("seedhs_busy", busy, 0);
      m_lfsr = s;
      take_word("seedhs_next", 8'h33, 9);

      // Randomized ena gaps, thresholds and consumer stalls.
      cap = 8'($urandom);
      do_reset(cap);
      ena = 1'b1;
      for (int n = 0; n < 300; n++) begin
         mask_ready = 1'b0;
         w          = model_word(cap);
         guard      = 0;
         while (!mask_valid && guard < 500) begin
            @(negedge clk);
            guard++;
            ena      = ($urandom_range(0, 3) != 0);
            keep_thr = 8'($urandom);
         end
         if (!mask_valid) begin
            check("rnd_timeout", 32'd0, 32'd1);
            break;
         end
         check("rnd_mask", mask, w);
         check("rnd_kc", keep_count, $countones(w));
         stall = $urandom_range(0, 3);
         for (int k = 0; k < stall; k++) begin
            ena      = 1'($urandom);
            keep_thr = 8'($urandom);
            @(negedge clk);
            check("rnd_stall_mask", mask, w);
            check("rnd_stall_valid", mask_valid, 1);
         end
         mask_ready = 1'b1;
         ena        = 1'b1;
         cap        = 8'($urandom);
         keep_thr   = cap;
         @(negedge clk);
         m_cnt++;
         check("rnd_cnt", mask_cnt, m_cnt % 256);
      end
      mask_ready = 1'b0;

      // Asynchronous reset mid-word clears outputs before the next edge.
      do_reset(8'h80);
      ena        = 1'b1;
      mask_ready = 1'b1;
      take_word("ar_w0", 8'h80, 9);
      take_word("ar_w1", 8'h80, 8);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_mask", mask, 0);
      check("ar_valid", mask_valid, 0);
      check("ar_kc", keep_count, 0);
      check("ar_cnt", mask_cnt, 0);
      check("ar_busy", busy, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = DSEED;
      m_cnt  = 0;
      take_word("ar_resume", 8'h80, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
